// File: rtl/node_link.sv
// Router-side endpoint of the credit-based flit link into one neuromorphic node.
// TX path paced by node credits; RX path buffered in a FWFT FIFO with per-pop credit return.
module node_link #(
    parameter int unsigned FW = 59,
    parameter int unsigned B  = 4,
    parameter int unsigned RB = 4
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_tx_vld,
    input  logic [FW-1:0] i_tx_flit,
    output logic          o_tx_rdy,
    output logic          o_node_flit_in_wr,
    output logic [FW-1:0] o_node_flit_in,
    input  logic          i_node_credit_out,
    input  logic          i_node_flit_out_wr,
    input  logic [FW-1:0] i_node_flit_out,
    output logic          o_node_credit_in,
    output logic          o_rx_vld,
    output logic [FW-1:0] o_rx_flit,
    input  logic          i_rx_rdy,
    output logic          o_idle,
    output logic          o_err_ovf,
    output logic          o_err_crd
);

    localparam int unsigned CW = $clog2(B + 1);
    localparam int unsigned PW = (RB > 1) ? $clog2(RB) : 1;
    localparam int unsigned OW = $clog2(RB + 1);
    localparam logic [CW-1:0] CntMax  = CW'(B);
    localparam logic [OW-1:0] OccMax  = OW'(RB);
    localparam logic [PW-1:0] PtrLast = PW'(RB - 1);

    // TX side state
    logic [CW-1:0] r_credit_cnt;
    logic          r_flit_in_wr;
    logic [FW-1:0] r_flit_in;
    logic          r_err_crd;

    // RX side state
    logic [FW-1:0] r_mem [RB];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [OW-1:0] r_occ;
    logic          r_credit_in;
    logic          r_err_ovf;

    logic w_send;
    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_push;

    assign o_tx_rdy = (r_credit_cnt != '0);
    assign w_send   = i_tx_vld & o_tx_rdy;

    assign w_full  = (r_occ == OccMax);
    assign w_empty = (r_occ == '0);
    assign w_pop   = ~w_empty & i_rx_rdy;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign w_push  = i_node_flit_out_wr & (~w_full | w_pop);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_credit_cnt <= CntMax;
            r_flit_in_wr <= 1'b0;
            r_flit_in    <= '0;
            r_err_crd    <= 1'b0;
        end else begin
            r_flit_in_wr <= w_send;
            if (w_send) begin
                r_flit_in <= i_tx_flit;
            end
            case ({w_send, i_node_credit_out})
                2'b10: r_credit_cnt <= r_credit_cnt - 1'b1;
                2'b01: begin
                    if (r_credit_cnt == CntMax) begin
                        r_err_crd <= 1'b1;
                    end else begin
                        r_credit_cnt <= r_credit_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < int'(RB); i++) begin
                r_mem[i] <= '0;
            end
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_occ       <= '0;
            r_credit_in <= 1'b0;
            r_err_ovf   <= 1'b0;
        end else begin
            r_credit_in <= w_pop;
            if (w_push) begin
                r_mem[r_wptr] <= i_node_flit_out;
                r_wptr        <= (r_wptr == PtrLast) ? '0 : r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == PtrLast) ? '0 : r_rptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_occ <= r_occ + 1'b1;
            end else if (!w_push && w_pop) begin
                r_occ <= r_occ - 1'b1;
            end
            if (i_node_flit_out_wr && w_full && !w_pop) begin
                r_err_ovf <= 1'b1;
            end
        end
    end

    assign o_node_flit_in_wr = r_flit_in_wr;
    assign o_node_flit_in    = r_flit_in;
    assign o_node_credit_in  = r_credit_in;
    assign o_rx_vld          = ~w_empty;
    assign o_rx_flit         = r_mem[r_rptr];
    assign o_err_ovf         = r_err_ovf;
    assign o_err_crd         = r_err_crd;
    assign o_idle            = (r_credit_cnt == CntMax) & w_empty & ~r_flit_in_wr & ~r_credit_in;

endmodule

// File: tb/tb_node_link.sv
// Self-checking bench for node_link: directed scenario tasks plus a queue-based
// reference monitor that checks every cycle at the falling edge.
module tb_node_link;

    localparam int FW = 59;
    localparam int B  = 4;
    localparam int RB = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tx_vld = 1'b0;
    logic [FW-1:0] tx_flit = '0;
    logic          tx_rdy;
    logic          node_flit_in_wr;
    logic [FW-1:0] node_flit_in;
    logic          node_credit_out = 1'b0;
    logic          node_flit_out_wr = 1'b0;
    logic [FW-1:0] node_flit_out = '0;
    logic          node_credit_in;
    logic          rx_vld;
    logic [FW-1:0] rx_flit;
    logic          rx_rdy = 1'b0;
    logic          idle;
    logic          err_ovf;
    logic          err_crd;

    int checks = 0;
    int errors = 0;

    node_link #(.FW(FW), .B(B), .RB(RB)) dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_tx_vld           (tx_vld),
        .i_tx_flit          (tx_flit),
        .o_tx_rdy           (tx_rdy),
        .o_node_flit_in_wr  (node_flit_in_wr),
        .o_node_flit_in     (node_flit_in),
        .i_node_credit_out  (node_credit_out),
        .i_node_flit_out_wr (node_flit_out_wr),
        .i_node_flit_out    (node_flit_out),
        .o_node_credit_in   (node_credit_in),
        .o_rx_vld           (rx_vld),
        .o_rx_flit          (rx_flit),
        .i_rx_rdy           (rx_rdy),
        .o_idle             (idle),
        .o_err_ovf          (err_ovf),
        .o_err_crd          (err_crd)
    );

    always #5 clk = ~clk;

    // Reference model state: credit count, RX scoreboard queue, expected strobes.
    int            m_cnt  = B;
    logic [FW-1:0] rxm[$];
    logic          m_wr   = 1'b0;
    logic [FW-1:0] m_flit = '0;
    logic          m_crd  = 1'b0;
    logic          m_eovf = 1'b0;
    logic          m_ecrd = 1'b0;
    logic          m_send;
    logic          m_pop;

    always @(negedge clk) begin
        if (rst) begin
            m_cnt = B;
            rxm.delete();
            m_wr = 1'b0;
            m_flit = '0;
            m_crd = 1'b0;
            m_eovf = 1'b0;
            m_ecrd = 1'b0;
        end else begin
            checks++;
            if (node_flit_in_wr !== m_wr) begin
                errors++;
                $display("FAIL mon_flit_in_wr t=%0t got %b want %b", $time, node_flit_in_wr, m_wr);
            end
            if (m_wr) begin
                checks++;
                if (node_flit_in !== m_flit) begin
                    errors++;
                    $display("FAIL mon_flit_in t=%0t got %h want %h", $time, node_flit_in, m_flit);
                end
            end
            checks++;
            if (tx_rdy !== (m_cnt != 0)) begin
                errors++;
                $display("FAIL mon_tx_rdy t=%0t got %b want %b", $time, tx_rdy, (m_cnt != 0));
            end
            checks++;
            if (node_credit_in !== m_crd) begin
                errors++;
                $display("FAIL mon_credit_in t=%0t got %b want %b", $time, node_credit_in, m_crd);
            end
            checks++;
            if (rx_vld !== (rxm.size() != 0)) begin
                errors++;
                $display("FAIL mon_rx_vld t=%0t got %b want %b", $time, rx_vld, (rxm.size() != 0));
            end
            if (rxm.size() != 0) begin
                checks++;
                if (rx_flit !== rxm[0]) begin
                    errors++;
                    $display("FAIL mon_rx_flit t=%0t got %h want %h", $time, rx_flit, rxm[0]);
                end
            end
            checks++;
            if (idle !== (m_cnt == B && rxm.size() == 0 && !m_wr && !m_crd)) begin
                errors++;
                $display("FAIL mon_idle t=%0t got %b", $time, idle);
            end
            checks++;
            if (err_ovf !== m_eovf || err_crd !== m_ecrd) begin
                errors++;
                $display("FAIL mon_err t=%0t got ovf=%b crd=%b want ovf=%b crd=%b",
                         $time, err_ovf, err_crd, m_eovf, m_ecrd);
            end
            m_send = tx_vld && (m_cnt != 0);
            m_pop  = (rxm.size() != 0) && rx_rdy;
            m_wr   = m_send;
            if (m_send) m_flit = tx_flit;
            if (m_send && !node_credit_out) begin
                m_cnt--;
            end else if (!m_send && node_credit_out) begin
                if (m_cnt == B) m_ecrd = 1'b1;
                else m_cnt++;
            end
            m_crd = m_pop;
            if (m_pop) void'(rxm.pop_front());
            if (node_flit_out_wr) begin
                if (rxm.size() < RB) rxm.push_back(node_flit_out);
                else m_eovf = 1'b1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++;
        if (tx_rdy !== 1'b1 || rx_vld !== 1'b0 || idle !== 1'b1) begin
            errors++;
            $display("FAIL reset_outs got rdy=%b vld=%b idle=%b want 1 0 1", tx_rdy, rx_vld, idle);
        end
        checks++;
        if (node_flit_in_wr !== 1'b0 || node_flit_in !== '0 || node_credit_in !== 1'b0 ||
            err_ovf !== 1'b0 || err_crd !== 1'b0) begin
            errors++;
            $display("FAIL reset_regs got wr=%b flit=%h crd=%b ovf=%b ecrd=%b want all 0",
                     node_flit_in_wr, node_flit_in, node_credit_in, err_ovf, err_crd);
        end
    endtask

    task automatic test_tx_fill();
        tx_vld = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tx_flit = FW'(c + 1);
            checks++;
            if (tx_rdy !== (c < 4)) begin
                errors++;
                $display("FAIL fill_rdy c=%0d got %b want %b", c, tx_rdy, (c < 4));
            end
            step();
            checks++;
            if (node_flit_in_wr !== (c < 4)) begin
                errors++;
                $display("FAIL fill_wr c=%0d got %b want %b", c, node_flit_in_wr, (c < 4));
            end
            if (c < 4) begin
                checks++;
                if (node_flit_in !== FW'(c + 1)) begin
                    errors++;
                    $display("FAIL fill_flit c=%0d got %h want %h", c, node_flit_in, c + 1);
                end
            end
        end
        checks++;
        if (tx_rdy !== 1'b0) begin
            errors++;
            $display("FAIL fill_stall got %b want 0", tx_rdy);
        end
    endtask

    task automatic test_credit_return();
        node_credit_out = 1'b1;
        step();
        node_credit_out = 1'b0;
        checks++;
        if (tx_rdy !== 1'b1 || node_flit_in_wr !== 1'b0) begin
            errors++;
            $display("FAIL crd_rdy got rdy=%b wr=%b want 1 0", tx_rdy, node_flit_in_wr);
        end
        step();
        checks++;
        if (node_flit_in_wr !== 1'b1 || node_flit_in !== FW'(5) || tx_rdy !== 1'b0) begin
            errors++;
            $display("FAIL crd_deliver got wr=%b flit=%h rdy=%b want 1 5 0",
                     node_flit_in_wr, node_flit_in, tx_rdy);
        end
        tx_vld = 1'b0;
    endtask

    task automatic test_send_and_credit();
        node_credit_out = 1'b1;
        step();
        for (int k = 0; k < 2; k++) begin
            tx_vld = 1'b1;
            tx_flit = FW'(48 + k);
            node_credit_out = 1'b1;
            step();
            checks++;
            if (node_flit_in_wr !== 1'b1 || node_flit_in !== FW'(48 + k) || tx_rdy !== 1'b1) begin
                errors++;
                $display("FAIL same_cycle k=%0d got wr=%b flit=%h rdy=%b want 1 %h 1",
                         k, node_flit_in_wr, node_flit_in, tx_rdy, 48 + k);
            end
        end
        tx_vld = 1'b0;
        node_credit_out = 1'b1;
        repeat (3) step();
        node_credit_out = 1'b0;
        step();
        checks++;
        if (idle !== 1'b1 || err_crd !== 1'b0) begin
            errors++;
            $display("FAIL refill_idle got idle=%b ecrd=%b want 1 0", idle, err_crd);
        end
    endtask

    task automatic test_rx_order();
        rx_rdy = 1'b0;
        for (int k = 0; k < 4; k++) begin
            node_flit_out_wr = 1'b1;
            node_flit_out = FW'(10 + k);
            step();
            checks++;
            if (rx_vld !== 1'b1 || rx_flit !== FW'(10) || node_credit_in !== 1'b0) begin
                errors++;
                $display("FAIL rx_fill k=%0d got vld=%b head=%h crd=%b want 1 a 0",
                         k, rx_vld, rx_flit, node_credit_in);
            end
        end
        node_flit_out_wr = 1'b0;
        rx_rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (rx_vld !== 1'b1 || rx_flit !== FW'(10 + k)) begin
                errors++;
                $display("FAIL rx_pop k=%0d got vld=%b head=%h want 1 %h", k, rx_vld, rx_flit, 10 + k);
            end
            step();
            checks++;
            if (node_credit_in !== 1'b1) begin
                errors++;
                $display("FAIL rx_credit k=%0d got %b want 1", k, node_credit_in);
            end
        end
        rx_rdy = 1'b0;
        step();
        checks++;
        if (rx_vld !== 1'b0 || node_credit_in !== 1'b0) begin
            errors++;
            $display("FAIL rx_drained got vld=%b crd=%b want 0 0", rx_vld, node_credit_in);
        end
    endtask

    task automatic test_overflow();
        logic [FW-1:0] exp_q[$];
        rx_rdy = 1'b0;
        node_flit_out_wr = 1'b1;
        for (int k = 0; k < 4; k++) begin
            node_flit_out = FW'(16 + k);
            step();
        end
        checks++;
        if (err_ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_early got %b want 0", err_ovf);
        end
        node_flit_out = FW'(14);
        step();
        checks++;
        if (err_ovf !== 1'b1 || rx_flit !== FW'(16)) begin
            errors++;
            $display("FAIL ovf_drop got ovf=%b head=%h want 1 10", err_ovf, rx_flit);
        end
        node_flit_out = FW'(32);
        rx_rdy = 1'b1;
        step();
        node_flit_out_wr = 1'b0;
        exp_q = '{FW'(17), FW'(18), FW'(19), FW'(32)};
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (rx_vld !== 1'b1 || rx_flit !== exp_q[k]) begin
                errors++;
                $display("FAIL ovf_drain k=%0d got vld=%b head=%h want 1 %h", k, rx_vld, rx_flit, exp_q[k]);
            end
            step();
        end
        rx_rdy = 1'b0;
        checks++;
        if (rx_vld !== 1'b0) begin
            errors++;
            $display("FAIL ovf_empty got %b want 0", rx_vld);
        end
        node_credit_out = 1'b1;
        step();
        node_credit_out = 1'b0;
        step();
        checks++;
        if (err_crd !== 1'b1 || err_ovf !== 1'b1 || idle !== 1'b1 || tx_rdy !== 1'b1) begin
            errors++;
            $display("FAIL crd_err got ecrd=%b ovf=%b idle=%b rdy=%b want 1 1 1 1",
                     err_crd, err_ovf, idle, tx_rdy);
        end
    endtask

    task automatic test_reset_mid();
        tx_vld = 1'b1;
        rx_rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tx_flit = FW'(64 + k);
            node_flit_out_wr = (k < 2);
            node_flit_out = FW'(80 + k);
            step();
        end
        tx_vld = 1'b0;
        node_flit_out_wr = 1'b0;
        checks++;
        if (tx_rdy !== 1'b1 || rx_vld !== 1'b1 || node_flit_in_wr !== 1'b1) begin
            errors++;
            $display("FAIL mid_setup got rdy=%b vld=%b wr=%b want 1 1 1", tx_rdy, rx_vld, node_flit_in_wr);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (rx_vld !== 1'b0 || tx_rdy !== 1'b1 || idle !== 1'b1 || err_ovf !== 1'b0 ||
            err_crd !== 1'b0 || node_flit_in_wr !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got vld=%b rdy=%b idle=%b ovf=%b ecrd=%b wr=%b want 0 1 1 0 0 0",
                     rx_vld, tx_rdy, idle, err_ovf, err_crd, node_flit_in_wr);
        end
        step();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (node_flit_in_wr !== 1'b0 || node_credit_in !== 1'b0 || idle !== 1'b1) begin
                errors++;
                $display("FAIL post_reset k=%0d got wr=%b crd=%b idle=%b want 0 0 1",
                         k, node_flit_in_wr, node_credit_in, idle);
            end
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        test_reset();
        test_tx_fill();
        test_credit_return();
        test_send_and_credit();
        test_rx_order();
        test_overflow();
        test_reset_mid();
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
